// File: rtl/dbus_mem_responder.sv
// Bridges dcache line/beat requests onto a one-beat-at-a-time backing memory port.
// One request in flight; bursts walk the aligned 512-bit line in 64-bit beats.
module dbus_mem_responder #(
  parameter int BEATS = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         dbus_index_valid,
  output logic         dbus_index_ready,
  input  logic [63:0]  dbus_index,
  input  logic [511:0] dbus_write_data,
  input  logic [1:0]   dbus_operation_type,
  input  logic         dbus_burst_mode,
  output logic [511:0] dbus_read_data,
  output logic         dbus_operation_done,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_we,
  output logic [63:0]  mem_req_addr,
  output logic [63:0]  mem_req_wdata,
  input  logic         mem_resp_valid,
  input  logic [63:0]  mem_resp_rdata
);
  localparam int            CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BURST = CW'(BEATS - 1);
  localparam logic [1:0]    OP_READ    = 2'b00;
  localparam logic [1:0]    OP_WRITE   = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [63:0]   idx_q;
  logic [511:0]  wdata_q;
  logic [1:0]    op_q;
  logic          burst_q;
  logic [CW-1:0] beat_cnt;
  logic [511:0]  rdata_q;

  logic          accept;
  logic          supported;
  logic          last_beat;
  logic          resp_fire;
  logic [63:0]   beat_addr;

  assign accept    = dbus_index_valid && (state == IDLE);
  assign supported = (dbus_operation_type == OP_READ) || (dbus_operation_type == OP_WRITE);
  assign last_beat = (beat_cnt == (burst_q ? LAST_BURST : '0));
  assign resp_fire = (state == WAIT) && mem_resp_valid;

  // beat_cnt never passes BEATS-1, so a burst never carries out of its line
  assign beat_addr = burst_q ? ((idx_q & ~64'h3F) + (64'(beat_cnt) << 3))
                             : (idx_q & ~64'h7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = supported ? REQ : DONE;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = last_beat ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      wdata_q  <= '0;
      op_q     <= '0;
      burst_q  <= 1'b0;
      beat_cnt <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      idx_q    <= dbus_index;
      wdata_q  <= dbus_write_data;
      op_q     <= dbus_operation_type;
      burst_q  <= dbus_burst_mode;
      beat_cnt <= '0;
      rdata_q  <= '0;
    end else if (resp_fire) begin
      if (op_q == OP_READ) rdata_q[{beat_cnt, 6'd0} +: 64] <= mem_resp_rdata;
      if (!last_beat) beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_comb begin
    dbus_index_ready    = (state == IDLE);
    dbus_operation_done = (state == DONE);
    dbus_read_data      = rdata_q;
    mem_req_valid       = 1'b0;
    mem_req_we          = 1'b0;
    mem_req_addr        = '0;
    mem_req_wdata       = '0;
    if (state == REQ) begin
      mem_req_valid = 1'b1;
      mem_req_we    = (op_q == OP_WRITE);
      mem_req_addr  = beat_addr;
      mem_req_wdata = wdata_q[{beat_cnt, 6'd0} +: 64];
    end
  end

  a_beat_cnt_range: assert property (@(posedge clock) disable iff (!reset_n)
    beat_cnt <= LAST_BURST);
  a_done_one_cycle: assert property (@(posedge clock) disable iff (!reset_n)
    (state == DONE) |=> (state == IDLE));

endmodule
